// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop sync, shared-prescaler debounce, rise/fall detect, sticky W1C events.
// Latency pad_i->gpio_o is 3 cycles with debounce off; no backpressure, every input is sampled each cycle.
module gpio_in_cond #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16,
    parameter int DB_CNT  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [WIDTH-1:0]   pad_i,
    input  logic [WIDTH-1:0]   db_en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [WIDTH-1:0]   rise_en_i,
    input  logic [WIDTH-1:0]   fall_en_i,
    input  logic [WIDTH-1:0]   evt_clr_i,
    output logic [WIDTH-1:0]   gpio_o,
    output logic [WIDTH-1:0]   evt_o,
    output logic               irq_o
);

    localparam int CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0]      C_LAST = CW'(DB_CNT - 1);
    localparam logic [CW-1:0]      C_ONE  = CW'(1);
    localparam logic [PRESC_W-1:0] P_ONE  = PRESC_W'(1);

    logic [WIDTH-1:0]   s1_q, s2_q;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [WIDTH-1:0]   evt_q, evt_d;
    logic [WIDTH-1:0]   rise, fall;
    logic [PRESC_W-1:0] p_q, p_d;
    logic [CW-1:0]      c_q [WIDTH];
    logic [CW-1:0]      c_d [WIDTH];
    logic               tick;

    // >= rather than == so lowering presc_i mid-count ticks next cycle instead of wrapping.
    always_comb begin
        tick = (p_q >= presc_i);
        p_d  = tick ? '0 : p_q + P_ONE;
    end

    always_comb begin
        f_d = f_q;
        for (int i = 0; i < WIDTH; i++) begin
            c_d[i] = c_q[i];
            if (!db_en_i[i]) begin
                f_d[i] = s2_q[i];
                c_d[i] = '0;
            end else if (s2_q[i] == f_q[i]) begin
                c_d[i] = '0;
            end else if (tick) begin
                if (c_q[i] == C_LAST) begin
                    f_d[i] = s2_q[i];
                    c_d[i] = '0;
                end else begin
                    c_d[i] = c_q[i] + C_ONE;
                end
            end
        end
    end

    // Set beats clear so an edge landing on a clear strobe is never lost.
    always_comb begin
        rise  = ~f_q & f_d;
        fall  = f_q & ~f_d;
        evt_d = (evt_q & ~evt_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_q  <= '0;
            s2_q  <= '0;
            f_q   <= '0;
            evt_q <= '0;
            p_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            s1_q  <= pad_i;
            s2_q  <= s1_q;
            f_q   <= f_d;
            evt_q <= evt_d;
            p_q   <= p_d;
            for (int i = 0; i < WIDTH; i++) begin
                c_q[i] <= c_d[i];
            end
        end
    end

    assign gpio_o = f_q;
    assign evt_o  = evt_q;
    assign irq_o  = |evt_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_gpio_in_cond;

    localparam int WIDTH   = 32;
    localparam int PRESC_W = 16;
    localparam int DB_CNT  = 4;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic [WIDTH-1:0]   pad_i, db_en_i, rise_en_i, fall_en_i, evt_clr_i;
    logic [PRESC_W-1:0] presc_i;
    logic [WIDTH-1:0]   gpio_o, evt_o;
    logic               irq_o;

    gpio_in_cond #(.WIDTH(WIDTH), .PRESC_W(PRESC_W), .DB_CNT(DB_CNT)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .pad_i     (pad_i),
        .db_en_i   (db_en_i),
        .presc_i   (presc_i),
        .rise_en_i (rise_en_i),
        .fall_en_i (fall_en_i),
        .evt_clr_i (evt_clr_i),
        .gpio_o    (gpio_o),
        .evt_o     (evt_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: pad delay line, filtered level, per-pin tick run length, events, prescaler.
    logic [31:0] m_s1, m_s2, m_f, m_evt;
    int          m_p;
    int          m_c [32];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_zero();
        m_s1 = '0; m_s2 = '0; m_f = '0; m_evt = '0; m_p = 0;
        for (int b = 0; b < 32; b++) m_c[b] = 0;
    endtask

    task automatic mdl_step();
        bit          tk;
        logic [31:0] nf, set;
        if (!reset_i) begin
            mdl_zero();
            return;
        end
        tk = (m_p >= int'(presc_i));
        nf = m_f;
        for (int b = 0; b < 32; b++) begin
            if (!db_en_i[b]) begin
                nf[b]  = m_s2[b];
                m_c[b] = 0;
            end else if (m_s2[b] == m_f[b]) begin
                m_c[b] = 0;
            end else if (tk) begin
                m_c[b] = m_c[b] + 1;
                if (m_c[b] == DB_CNT) begin
                    nf[b]  = m_s2[b];
                    m_c[b] = 0;
                end
            end
        end
        set   = (nf & ~m_f & rise_en_i) | (m_f & ~nf & fall_en_i);
        m_evt = (m_evt & ~evt_clr_i) | set;
        m_f   = nf;
        m_s2  = m_s1;
        m_s1  = pad_i;
        m_p   = tk ? 0 : m_p + 1;
    endtask

    // One clock: advance the model with the inputs now applied, then compare just after the edge.
    task automatic step();
        mdl_step();
        @(posedge clk_i);
        #1;
        check_val("mdl_gpio", gpio_o, m_f);
        check_val("mdl_evt", evt_o, m_evt);
        check_val("mdl_irq", {31'b0, irq_o}, {31'b0, |m_evt});
    endtask

    initial begin
        int  k;
        bit  seen;
        reset_i   = 1'b0;
        pad_i     = '0;
        db_en_i   = '0;
        rise_en_i = '0;
        fall_en_i = '0;
        evt_clr_i = '0;
        presc_i   = '0;
        mdl_zero();
        #1;
        check_val("rst_gpio", gpio_o, 32'h0);
        check_val("rst_evt", evt_o, 32'h0);
        check_val("rst_irq", {31'b0, irq_o}, 32'h0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        step();

        // Plain path: pad rise shows on gpio_o and evt_o three cycles later.
        pad_i = 32'h1;
        rise_en_i = 32'h1;
        step(); step();
        check_val("lat_gpio_early", gpio_o, 32'h0);
        step();
        check_val("lat_gpio", gpio_o, 32'h1);
        check_val("lat_evt", evt_o, 32'h1);
        check_val("lat_irq", {31'b0, irq_o}, 32'h1);
        evt_clr_i = 32'h1; step(); evt_clr_i = '0;
        check_val("clr0_evt", evt_o, 32'h0);

        // Debounced rise on pin 1 with a tick every 4 cycles.
        db_en_i = 32'h2;
        presc_i = 16'd3;
        step();
        pad_i[1] = 1'b1;
        k = 0;
        while (k < 40 && !gpio_o[1]) begin step(); k++; end
        check_val("db_rise_window", {31'b0, (k >= 15 && k <= 18)}, 32'h1);
        pad_i[1] = 1'b0;
        for (int i = 0; i < 30; i++) step();

        // An 8-cycle glitch must be swallowed.
        pad_i[1] = 1'b1;
        for (int i = 0; i < 8; i++) step();
        pad_i[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin step(); seen |= gpio_o[1] | evt_o[1]; end
        check_val("db_glitch", {31'b0, seen}, 32'h0);

        // A 20-cycle pulse passes, and its fall is debounced too.
        pad_i[1] = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_val("db_pulse_hi", {31'b0, gpio_o[1]}, 32'h1);
        pad_i[1] = 1'b0;
        k = 0;
        while (k < 40 && gpio_o[1]) begin step(); k++; end
        check_val("db_fall_window", {31'b0, (k >= 15 && k <= 18)}, 32'h1);

        // Pin 2: fall-only events.
        fall_en_i = 32'h4;
        pad_i[2] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_val("p2_rise_noevt", {31'b0, evt_o[2]}, 32'h0);
        check_val("p2_gpio_hi", {31'b0, gpio_o[2]}, 32'h1);
        pad_i[2] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_val("p2_fall_evt", {31'b0, evt_o[2]}, 32'h1);
        evt_clr_i = 32'h4; step(); evt_clr_i = '0;
        check_val("p2_clr", {31'b0, evt_o[2]}, 32'h0);

        // Pin 3: fall lands on the same edge as a clear strobe.
        fall_en_i = 32'hC;
        pad_i[3] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        pad_i[3] = 1'b0;
        step(); step();
        evt_clr_i = 32'h8; step(); evt_clr_i = '0;
        check_val("p3_set_wins", {31'b0, evt_o[3]}, 32'h1);
        check_val("p3_gpio_lo", {31'b0, gpio_o[3]}, 32'h0);
        evt_clr_i = 32'h8; step(); evt_clr_i = '0;
        check_val("p3_clr", {31'b0, evt_o[3]}, 32'h0);

        // Reset mid-debounce, then release with pin 4 held high.
        db_en_i = 32'h10;
        pad_i   = 32'h10;
        k = 0;
        while (k < 40 && m_c[4] != 2) begin step(); k++; end
        check_val("p4_reach_c2", {31'b0, (k < 40)}, 32'h1);
        #2;
        reset_i = 1'b0;
        mdl_zero();
        #1;
        check_val("arst_gpio", gpio_o, 32'h0);
        check_val("arst_evt", evt_o, 32'h0);
        check_val("arst_irq", {31'b0, irq_o}, 32'h0);
        db_en_i   = '0;
        rise_en_i = 32'h10;
        step();
        reset_i = 1'b1;
        step(); step();
        check_val("p4_early", gpio_o, 32'h0);
        step();
        check_val("p4_gpio", gpio_o, 32'h10);
        check_val("p4_evt", evt_o, 32'h10);
        check_val("p4_irq", {31'b0, irq_o}, 32'h1);

        // Randomized traffic, including presc_i changes mid-count and one reset pulse.
        for (int i = 0; i < 600; i++) begin
            pad_i     = pad_i ^ ($urandom & $urandom & $urandom & $urandom & $urandom);
            evt_clr_i = $urandom & $urandom & $urandom;
            if (i % 64 == 0) begin
                db_en_i   = $urandom;
                rise_en_i = $urandom;
                fall_en_i = $urandom;
            end
            if (i % 50 == 0) presc_i = PRESC_W'($urandom_range(0, 4));
            if (i == 300) begin
                reset_i = 1'b0;
                mdl_zero();
                #1;
                check_val("rnd_arst_gpio", gpio_o, 32'h0);
                check_val("rnd_arst_evt", evt_o, 32'h0);
            end
            if (i == 302) reset_i = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
